// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: round-robin front end that shares one modexp engine between
// two requesters. It holds the operands for the whole run and buffers each result.
module rsa_job_arbiter #(
  parameter int W     = 256,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [W-1:0]     i_req0_a,
  input  logic [W-1:0]     i_req0_d,
  input  logic [W-1:0]     i_req0_n,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [W-1:0]     o_rsp0_data,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [W-1:0]     i_req1_a,
  input  logic [W-1:0]     i_req1_d,
  input  logic [W-1:0]     i_req1_n,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [W-1:0]     o_rsp1_data,
  output logic             o_eng_start,
  output logic [W-1:0]     o_eng_a,
  output logic [W-1:0]     o_eng_d,
  output logic [W-1:0]     o_eng_n,
  input  logic             i_eng_finished,
  input  logic [W-1:0]     i_eng_result,
  output logic             o_busy,
  output logic             o_grant_id,
  output logic [CNT_W-1:0] o_jobs_done,
  output logic             o_err_spurious
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         last_grant;
  logic         grant;
  logic         elig0;
  logic         elig1;
  logic         accept;
  logic         finish_ok;
  logic [W-1:0] op_a;
  logic [W-1:0] op_d;
  logic [W-1:0] op_n;

  // A requester still holding an unread result may not start another job.
  assign elig0     = i_req0_valid && !o_rsp0_valid;
  assign elig1     = i_req1_valid && !o_rsp1_valid;
  assign grant     = (elig0 && elig1) ? ~last_grant : elig1;
  assign accept    = o_req0_ready || o_req1_ready;
  assign finish_ok = (state == S_WAIT) && i_eng_finished;

  assign o_eng_a = op_a;
  assign o_eng_d = op_d;
  assign o_eng_n = op_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (i_eng_finished) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_eng_start  = (state == S_START);
    o_busy       = (state != S_IDLE);
    if (state == S_IDLE) begin
      o_req0_ready = !grant && elig0;
      o_req1_ready = grant && elig1;
    end
  end

  // Operands only move on an accept, so the engine sees them stable all run.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_a       <= '0;
      op_d       <= '0;
      op_n       <= '0;
      o_grant_id <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op_a       <= grant ? i_req1_a : i_req0_a;
      op_d       <= grant ? i_req1_d : i_req0_d;
      op_n       <= grant ? i_req1_n : i_req0_n;
      o_grant_id <= grant;
      last_grant <= grant;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp0_valid   <= 1'b0;
      o_rsp1_valid   <= 1'b0;
      o_rsp0_data    <= '0;
      o_rsp1_data    <= '0;
      o_jobs_done    <= '0;
      o_err_spurious <= 1'b0;
    end else begin
      if (o_rsp0_valid && i_rsp0_ready) o_rsp0_valid <= 1'b0;
      if (o_rsp1_valid && i_rsp1_ready) o_rsp1_valid <= 1'b0;
      if (finish_ok) begin
        o_jobs_done <= o_jobs_done + CNT_W'(1);
        if (o_grant_id) begin
          o_rsp1_valid <= 1'b1;
          o_rsp1_data  <= i_eng_result;
        end else begin
          o_rsp0_valid <= 1'b1;
          o_rsp0_data  <= i_eng_result;
        end
      end
      if (i_eng_finished && (state != S_WAIT)) o_err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// tb_rsa_job_arbiter: drives two requesters and a behavioural engine, checking the
// arbiter against a transaction-level model plus a table and directed sequences.
module tb_rsa_job_arbiter;
  localparam int W     = 256;
  localparam int CNT_W = 2;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_req0_valid, i_req1_valid;
  logic             o_req0_ready, o_req1_ready;
  logic [W-1:0]     i_req0_a, i_req0_d, i_req0_n;
  logic [W-1:0]     i_req1_a, i_req1_d, i_req1_n;
  logic             o_rsp0_valid, o_rsp1_valid;
  logic             i_rsp0_ready, i_rsp1_ready;
  logic [W-1:0]     o_rsp0_data, o_rsp1_data;
  logic             o_eng_start;
  logic [W-1:0]     o_eng_a, o_eng_d, o_eng_n;
  logic             i_eng_finished;
  logic [W-1:0]     i_eng_result;
  logic             o_busy, o_grant_id, o_err_spurious;
  logic [CNT_W-1:0] o_jobs_done;

  always #5 i_clk = ~i_clk;

  rsa_job_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_a(i_req0_a), .i_req0_d(i_req0_d), .i_req0_n(i_req0_n),
    .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready), .o_rsp0_data(o_rsp0_data),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_a(i_req1_a), .i_req1_d(i_req1_d), .i_req1_n(i_req1_n),
    .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready), .o_rsp1_data(o_rsp1_data),
    .o_eng_start(o_eng_start), .o_eng_a(o_eng_a), .o_eng_d(o_eng_d), .o_eng_n(o_eng_n),
    .i_eng_finished(i_eng_finished), .i_eng_result(i_eng_result),
    .o_busy(o_busy), .o_grant_id(o_grant_id), .o_jobs_done(o_jobs_done),
    .o_err_spurious(o_err_spurious)
  );

  typedef struct {
    int cycles;
    bit v0;
    bit r0;
    bit x_ready0;
    bit x_start;
    bit x_busy;
    bit x_rv0;
    int x_data;
    int x_done;
  } vec_t;

  vec_t tbl[7];
  int   checks = 0;
  int   failures = 0;

  logic [W-1:0] s_a[2], s_d[2], s_n[2];

  // Job-level model: who is in flight, what is buffered, what must come back.
  bit           m_busy, m_start_due, m_gid, m_last, m_err;
  bit           m_pend[2];
  logic [W-1:0] m_pdata[2];
  logic [W-1:0] m_cur_a, m_cur_d, m_cur_n, m_res;
  int           m_done;

  bit           e_run, e_real_fin, spur_req;
  int           e_cnt, e_lat;
  logic [W-1:0] e_a, e_d, e_n;

  int acc, nfin;
  bit fin_pend, served1, got0;
  int exp_done[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  function automatic logic [W-1:0] modexp(input logic [W-1:0] a, input logic [W-1:0] d,
                                          input logic [W-1:0] n);
    longint unsigned r, b, e, m;
    logic [W-1:0] res;
    res = '0;
    m = longint'(n[31:0]);
    if (m == 0) return res;
    r = 1 % m;
    b = longint'(a[31:0]) % m;
    e = longint'(d[31:0]);
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    res[63:0] = r;
    return res;
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void expReady(output bit r0, output bit r1);
    bit e0, e1;
    e0 = i_req0_valid && !m_pend[0];
    e1 = i_req1_valid && !m_pend[1];
    r0 = 1'b0;
    r1 = 1'b0;
    if (!m_busy) begin
      if (e0 && e1) begin
        r0 = m_last;
        r1 = !m_last;
      end else begin
        r0 = e0;
        r1 = e1;
      end
    end
  endfunction

  task automatic modelReset();
    m_busy = 0; m_start_due = 0; m_gid = 0; m_last = 1; m_err = 0; m_done = 0;
    m_pend[0] = 0; m_pend[1] = 0; m_pdata[0] = '0; m_pdata[1] = '0;
    m_cur_a = '0; m_cur_d = '0; m_cur_n = '0; m_res = '0;
    e_run = 0; e_real_fin = 0; spur_req = 0;
  endtask

  task automatic checkOutput();
    bit r0, r1;
    expReady(r0, r1);
    checkBit("req0_ready", o_req0_ready, r0);
    checkBit("req1_ready", o_req1_ready, r1);
    checkBit("eng_start", o_eng_start, m_start_due);
    checkBit("busy", o_busy, m_busy);
    checkBit("grant_id", o_grant_id, m_gid);
    checkBit("rsp0_valid", o_rsp0_valid, m_pend[0]);
    checkBit("rsp1_valid", o_rsp1_valid, m_pend[1]);
    checkVal("rsp0_data", o_rsp0_data, m_pdata[0]);
    checkVal("rsp1_data", o_rsp1_data, m_pdata[1]);
    checkVal("eng_a", o_eng_a, m_cur_a);
    checkVal("eng_d", o_eng_d, m_cur_d);
    checkVal("eng_n", o_eng_n, m_cur_n);
    checkVal("jobs_done", W'(o_jobs_done), W'(m_done));
    checkBit("err_spurious", o_err_spurious, m_err);
  endtask

  // Advance the model across the coming clock edge from the inputs now applied.
  task automatic predictEdge();
    bit r0, r1;
    expReady(r0, r1);
    if (m_pend[0] && i_rsp0_ready) m_pend[0] = 0;
    if (m_pend[1] && i_rsp1_ready) m_pend[1] = 0;
    if (i_eng_finished) begin
      if (m_busy && !m_start_due) begin
        m_pend[m_gid]  = 1;
        m_pdata[m_gid] = m_res;
        m_done         = (m_done + 1) % (1 << CNT_W);
        m_busy         = 0;
      end else begin
        m_err = 1;
      end
    end
    m_start_due = 0;
    if (r0 || r1) begin
      m_busy = 1; m_start_due = 1; m_gid = r1; m_last = r1;
      m_cur_a = r1 ? i_req1_a : i_req0_a;
      m_cur_d = r1 ? i_req1_d : i_req0_d;
      m_cur_n = r1 ? i_req1_n : i_req0_n;
      m_res   = modexp(m_cur_a, m_cur_d, m_cur_n);
    end
  endtask

  task automatic engineDrive();
    i_eng_finished = 1'b0;
    e_real_fin = 1'b0;
    if (e_run) begin
      e_cnt--;
      if (e_cnt <= 0) begin
        i_eng_finished = 1'b1;
        i_eng_result   = modexp(e_a, e_d, e_n);
        e_run = 0;
        e_real_fin = 1'b1;
      end
    end else if (o_eng_start) begin
      e_a = o_eng_a; e_d = o_eng_d; e_n = o_eng_n;
      e_run = 1; e_cnt = e_lat;
    end
    if (spur_req) begin
      i_eng_finished = 1'b1;
      i_eng_result   = '1;
      spur_req = 0;
    end
  endtask

  task automatic applyStimulus(input bit v0, input bit v1, input bit r0, input bit r1);
    i_req0_valid = v0; i_req1_valid = v1;
    i_rsp0_ready = r0; i_rsp1_ready = r1;
    i_req0_a = s_a[0]; i_req0_d = s_d[0]; i_req0_n = s_n[0];
    i_req1_a = s_a[1]; i_req1_d = s_d[1]; i_req1_n = s_n[1];
  endtask

  task automatic runCycle(input bit v0, input bit v1, input bit r0, input bit r1);
    @(negedge i_clk);
    engineDrive();
    applyStimulus(v0, v1, r0, r1);
    #1;
    checkOutput();
    predictEdge();
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    i_eng_finished = 1'b0;
    i_eng_result = '0;
    modelReset();
    #1;
    checkOutput();
    @(negedge i_clk);
    #1;
    checkOutput();
    i_rst = 1'b0;
  endtask

  task automatic setKnownOps();
    s_a[0] = 4; s_d[0] = 13; s_n[0] = 497;
    s_a[1] = 5; s_d[1] = 3;  s_n[1] = 33;
  endtask

  initial begin
    i_rst = 1'b1;
    e_lat = 20;
    setKnownOps();
    applyStimulus(0, 0, 0, 0);
    i_eng_finished = 1'b0;
    i_eng_result = '0;
    modelReset();
    doReset();

    tbl[0] = '{1,  1, 0, 1, 0, 0, 0, 0,   0};
    tbl[1] = '{1,  0, 0, 0, 1, 1, 0, 0,   0};
    tbl[2] = '{20, 0, 0, 0, 0, 1, 0, 0,   0};
    tbl[3] = '{1,  0, 0, 0, 0, 0, 1, 445, 1};
    tbl[4] = '{2,  0, 0, 0, 0, 0, 1, 445, 1};
    tbl[5] = '{1,  0, 1, 0, 0, 0, 1, 445, 1};
    tbl[6] = '{1,  0, 0, 0, 0, 0, 0, 0,   1};
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) begin
        runCycle(tbl[i].v0, 0, tbl[i].r0, 1);
        checkBit("tbl_ready0", o_req0_ready, tbl[i].x_ready0);
        checkBit("tbl_start", o_eng_start, tbl[i].x_start);
        checkBit("tbl_busy", o_busy, tbl[i].x_busy);
        checkBit("tbl_rsp0_valid", o_rsp0_valid, tbl[i].x_rv0);
        if (tbl[i].x_rv0) checkVal("tbl_rsp0_data", o_rsp0_data, W'(tbl[i].x_data));
        checkVal("tbl_jobs_done", W'(o_jobs_done), W'(tbl[i].x_done));
      end
    end

    // Both requesters always valid: grants must alternate and the counter wrap.
    doReset();
    e_lat = 3;
    acc = 0; nfin = 0; fin_pend = 0;
    for (int cyc = 0; cyc < 400 && nfin < 8; cyc++) begin
      runCycle(1, 1, 1, 1);
      if (fin_pend) begin
        checkVal("rr_jobs_done", W'(o_jobs_done), W'(exp_done[nfin]));
        nfin++;
      end
      fin_pend = e_real_fin;
      if (o_req0_ready || o_req1_ready) begin
        checkBit("rr_grant_order", o_req1_ready, 1'(acc % 2));
        acc++;
      end
    end
    checkBit("rr_completed_all", nfin >= 8, 1'b1);

    // Held response on requester 0 blocks it while requester 1 keeps running.
    doReset();
    for (int cyc = 0; cyc < 50 && !o_rsp0_valid; cyc++) runCycle(1, 0, 0, 1);
    checkBit("bp_rsp0_valid", o_rsp0_valid, 1'b1);
    served1 = 0;
    for (int c = 0; c < 20; c++) begin
      runCycle(1, 1, 0, 1);
      checkBit("bp_ready0", o_req0_ready, 1'b0);
      checkVal("bp_rsp0_data", o_rsp0_data, W'(445));
      served1 = served1 | o_req1_ready;
    end
    checkBit("bp_req1_served", served1, 1'b1);
    runCycle(1, 1, 1, 1);
    got0 = 0;
    for (int c = 0; c < 20 && !got0; c++) begin
      runCycle(1, 1, 0, 1);
      got0 = o_req0_ready;
    end
    checkBit("bp_ready0_after_consume", got0, 1'b1);

    // Operand inputs churn after the accept; the engine view must not.
    doReset();
    e_lat = 20;
    runCycle(1, 0, 1, 1);
    for (int c = 0; c < 30; c++) begin
      s_a[0] = W'($urandom); s_d[0] = W'($urandom); s_n[0] = W'($urandom);
      runCycle(0, 0, 0, 1);
    end
    checkBit("stab_rsp0_valid", o_rsp0_valid, 1'b1);
    checkVal("stab_rsp0_data", o_rsp0_data, W'(445));
    runCycle(0, 0, 1, 1);
    setKnownOps();

    runCycle(0, 0, 0, 1);
    spur_req = 1;
    runCycle(0, 0, 0, 1);
    runCycle(0, 0, 0, 1);
    checkBit("spur_err", o_err_spurious, 1'b1);
    checkBit("spur_no_rsp", o_rsp0_valid | o_rsp1_valid, 1'b0);
    checkVal("spur_jobs_done", W'(o_jobs_done), W'(1));

    // Reset lands while the engine is busy; the next job must still complete.
    runCycle(1, 0, 1, 1);
    for (int c = 0; c < 5; c++) runCycle(0, 0, 1, 1);
    checkBit("mid_busy", o_busy, 1'b1);
    doReset();
    checkBit("rst_busy", o_busy, 1'b0);
    checkBit("rst_err", o_err_spurious, 1'b0);
    checkVal("rst_jobs_done", W'(o_jobs_done), W'(0));
    e_lat = 4;
    runCycle(1, 0, 0, 1);
    for (int c = 0; c < 30 && !o_rsp0_valid; c++) runCycle(0, 0, 0, 1);
    checkVal("rst_job_data", o_rsp0_data, W'(445));
    checkVal("rst_job_done", W'(o_jobs_done), W'(1));

    doReset();
    for (int c = 0; c < 3000; c++) begin
      for (int x = 0; x < 2; x++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_n[x] = W'($urandom_range(2, 65535));
          s_a[x] = W'($urandom_range(0, 65535)) % s_n[x];
          s_d[x] = W'($urandom_range(0, 65535));
        end
      end
      if (!e_run) e_lat = $urandom_range(1, 6);
      if ((!m_busy || m_start_due) && $urandom_range(0, 40) == 0) spur_req = 1;
      runCycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsa_job_arbiter.md
Name: rsa_job_arbiter

Overview:
Shares one 256-bit RSA modular-exponentiation engine between two requesters (e.g. two serial/host front-ends).
- Accepts jobs (a, d, n) over valid/ready, arbitrating round-robin.
- Captures and holds operands stable for the whole engine run, and pulses the engine start.
- Routes the engine result to a per-requester response buffer with a valid/ready handshake.
- Sits between the I/O wrappers and the engine; the engine samples start only when idle, reads a/d/n continuously while running, and emits a 1-cycle finished pulse with the result valid in that cycle.

Parameters:
W, 256, operand/result width
CNT_W, 16, width of completed-job counter

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_req0_valid  in  1  requester 0 job valid
o_req0_ready  out  1  requester 0 job accepted when valid&ready
i_req0_a / i_req0_d / i_req0_n  in  W each  requester 0 base, exponent, modulus
o_rsp0_valid  out  1  requester 0 result valid
i_rsp0_ready  in  1  requester 0 consumes result
o_rsp0_data  out  W  requester 0 result a^d mod n
i_req1_* / o_req1_ready / o_rsp1_* / i_rsp1_ready  same as requester 0, for requester 1
o_eng_start  out  1  1-cycle engine start pulse
o_eng_a / o_eng_d / o_eng_n  out  W each  held operands to engine
i_eng_finished  in  1  engine done pulse
i_eng_result  in  W  engine result, valid with i_eng_finished
o_busy  out  1  job in flight (state != S_IDLE)
o_grant_id  out  1  requester owning current/last job
o_jobs_done  out  CNT_W  completed-job count, wraps
o_err_spurious  out  1  sticky: i_eng_finished seen outside S_WAIT

Behaviour:
Reset values:
- All outputs and registers 0, state S_IDLE.
- last_grant = 1, so requester 0 wins the first tie.

Eligibility:
- elig_x = i_reqx_valid && !o_rspx_valid.
- A requester with an unconsumed result cannot issue a new job.

FSM:
- S_IDLE: grant = the only eligible requester; if both are eligible, grant = ~last_grant.
  - o_reqx_ready = (state==S_IDLE) && (grant==x) && elig_x; combinational, at most one high.
  - On handshake: latch a/d/n into the operand registers, set o_grant_id and last_grant = x, go to S_START.
- S_START: o_eng_start = 1 for exactly this cycle; go to S_WAIT.
- S_WAIT: on i_eng_finished, load i_eng_result into o_rspx_data for x = o_grant_id, set o_rspx_valid, increment o_jobs_done, go to S_IDLE.
- Accept at edge T → o_eng_start high in cycle T+1. Finished at edge F → rsp valid from F+1. Earliest next accept is edge F+1.

Operand hold:
- o_eng_a/d/n are driven only from the operand registers.
- They change only on an accept edge and are stable from S_START through the finished cycle.

Response buffers:
- Independent per requester.
- o_rspx_valid holds until edge with i_rspx_ready; data stable while valid.
- The other requester's job may run while one response is pending.
- i_rspx_ready with valid low is ignored.

Simultaneous events:
- rsp0 consume and req0 valid in the same cycle: req0 not eligible that cycle (eligibility uses the registered valid); eligible next cycle.
- A finished pulse to x cannot collide with a pending rsp_x, since elig_x prevents it.

Error handling:
- i_eng_finished in S_IDLE or S_START: ignored for data and counter; sets o_err_spurious.

Wrap-around:
- o_jobs_done wraps from 2^CNT_W−1 to 0.

Reset mid-job:
- Returns to S_IDLE, clears response valids, discards the in-flight job.
- The engine shares i_rst.

Test Plan:
- Single job: req0 a=4, d=13, n=497 with engine model (finish 20 cycles after start) → ready0 one cycle, o_eng_start one cycle later, rsp0 data=445 one cycle after finished, o_jobs_done=1, o_grant_id=0.
- Tie and round-robin: both valid from reset, four back-to-back jobs each, rsp ready tied 1 → grant order 0,1,0,1,…; each response routed to the correct requester (req1 a=5, d=3, n=33 → 26).
- Backpressure: rsp0_ready=0 after job0 completes, req0 and req1 valid → req1 served, req0 ready stays 0 until rsp0 consumed; rsp0 data 445 held stable throughout.
- Operand stability: change i_req0_a/d/n every cycle after accept → o_eng_a/d/n constant until finished; result still 445.
- Spurious/reset: pulse i_eng_finished in S_IDLE → o_err_spurious=1, no response, counter unchanged. Assert i_rst during S_WAIT → all outputs 0; a subsequent job completes normally.
- Counter wrap: CNT_W=2, run five jobs → o_jobs_done sequence 1,2,3,0,1.
